// File: rtl/addcmpand_unit_pkg.sv
// Shared constants for the add/complement/AND unit.
//   WIDTH   : operand and result width
//   NIB     : bits handled per cycle by the serial adder
//   NNIB    : nibbles per operand (serial add length in cycles)
//   CNT_W   : width of the nibble counter
//   OP_*    : operation encodings presented on the op port
//   IDLE/RUN: control FSM state encodings
package addcmpand_unit_pkg;

  localparam int WIDTH = 16;
  localparam int NIB   = 4;
  localparam int NNIB  = WIDTH / NIB;
  localparam int CNT_W = $clog2(NNIB);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_CMP = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/addcmpand_unit_nibble_add4.sv
// Combinational NIB-bit ripple adder slice shared by ADD and CMP.
//   a, b : nibble operands
//   cin  : carry in
//   sum  : nibble sum
//   cout : carry out of the nibble
module nibble_add4
  import addcmpand_unit_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] sum,
  output logic           cout
);

  logic [NIB:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{NIB{1'b0}}, cin};
  assign sum   = total[NIB-1:0];
  assign cout  = total[NIB];

endmodule

// File: rtl/addcmpand_unit.sv
// Multi-cycle 16-bit add / two's-complement / AND unit with start/busy/done
// handshake. ADD and CMP run through one shared nibble adder, LSB nibble
// first, finishing on the fourth edge after accept; AND and the reserved
// op finish on the first edge after accept.
//   CK, RST : clock (rising edge), asynchronous active-high reset
//   start   : request, honoured only while idle
//   op      : 0=ADD, 1=CMP (negate in1), 2=AND, 3=reserved (result 0)
//   in1,in2 : operands, latched at accept
//   out     : result register, holds the last completed result
//   carry   : carry out of the top bit (ADD/CMP), else 0
//   ovf     : signed overflow (ADD/CMP), else 0
//   busy    : operation in flight
//   done    : one-cycle pulse on the edge that updates out/carry/ovf
module addcmpand_unit
  import addcmpand_unit_pkg::*;
(
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic [1:0]       op_q;
  logic             cy;
  logic [NIB-1:0]   nsum;
  logic             ncout;
  logic             last;
  logic [WIDTH-1:0] sum_full;

  nibble_add4 u_add (
    .a    (a_sr[NIB-1:0]),
    .b    (b_sr[NIB-1:0]),
    .cin  (cy),
    .sum  (nsum),
    .cout (ncout)
  );

  assign busy     = (state == RUN);
  assign last     = (cnt == CNT_W'(NNIB - 1));
  // Completed sums enter acc from the top, so after the last nibble the
  // earlier nibbles sit in the upper bits of acc, already in order.
  assign sum_full = {nsum, acc[WIDTH-1:NIB]};

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      op_q  <= OP_ADD;
      cy    <= 1'b0;
      out   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            cnt   <= '0;
            acc   <= '0;
            state <= RUN;
            // Negation is ~in1 + 0 with the initial carry-in forced to 1.
            if (op == OP_CMP) begin
              a_sr <= ~in1;
              b_sr <= '0;
              cy   <= 1'b1;
            end else begin
              a_sr <= in1;
              b_sr <= in2;
              cy   <= 1'b0;
            end
          end
        end
        RUN: begin
          if (op_q == OP_ADD || op_q == OP_CMP) begin
            a_sr <= a_sr >> NIB;
            b_sr <= b_sr >> NIB;
            acc  <= sum_full;
            cy   <= ncout;
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
              out   <= sum_full;
              carry <= ncout;
              // On the last nibble a_sr/b_sr[NIB-1] are the operand sign bits.
              ovf   <= (a_sr[NIB-1] == b_sr[NIB-1]) && (nsum[NIB-1] != a_sr[NIB-1]);
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            out   <= (op_q == OP_AND) ? (a_sr & b_sr) : '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addcmpand_unit.sv
module tb_addcmpand_unit;

  logic        CK;
  logic        RST;
  logic        start;
  logic [1:0]  op;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [15:0] out;
  logic        carry;
  logic        ovf;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  addcmpand_unit dut (
    .CK    (CK),
    .RST   (RST),
    .start (start),
    .op    (op),
    .in1   (in1),
    .in2   (in2),
    .out   (out),
    .carry (carry),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  // Issue one operation, check busy across its latency and the result on done.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] eo, input logic ec,
                        input logic ev, input int lat);
    start = 1'b1; op = o; in1 = a; in2 = b;
    step();
    start = 1'b0;
    chk({tag, "_busy_acc"}, 16'(busy), 16'd1);
    chk({tag, "_done_acc"}, 16'(done), 16'd0);
    for (int i = 1; i <= lat; i++) begin
      step();
      if (i < lat) begin
        chk({tag, "_busy_mid"}, 16'(busy), 16'd1);
        chk({tag, "_done_mid"}, 16'(done), 16'd0);
      end
    end
    chk({tag, "_done"},  16'(done),  16'd1);
    chk({tag, "_busy"},  16'(busy),  16'd0);
    chk({tag, "_out"},   out,        eo);
    chk({tag, "_carry"}, 16'(carry), 16'(ec));
    chk({tag, "_ovf"},   16'(ovf),   16'(ev));
    step();
    chk({tag, "_done_off"}, 16'(done), 16'd0);
  endtask

  initial begin
    int pulses;
    tests = 0; fails = 0;
    RST = 1'b1; start = 1'b0; op = 2'd0; in1 = 16'h0; in2 = 16'h0;
    step(); step();
    chk("rst_out",   out,        16'h0000);
    chk("rst_busy",  16'(busy),  16'd0);
    chk("rst_done",  16'(done),  16'd0);
    chk("rst_carry", 16'(carry), 16'd0);
    chk("rst_ovf",   16'(ovf),   16'd0);
    RST = 1'b0;
    step();

    // Basic ADD and boundaries
    run_op("add1", 2'd0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 4);
    run_op("add2", 2'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 4);
    run_op("add3", 2'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 4);
    run_op("add4", 2'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 4);

    // Mid-operation reset: out was 0x0000 from add4, so load a nonzero value first
    run_op("add5", 2'd0, 16'h0F0F, 16'h0101, 16'h1010, 1'b0, 1'b0, 4);
    start = 1'b1; op = 2'd0; in1 = 16'h1234; in2 = 16'h4321;
    step();
    start = 1'b0;
    step(); step();
    RST = 1'b1;
    #1;
    chk("mrst_busy", 16'(busy), 16'd0);
    chk("mrst_out",  out,       16'h0000);
    chk("mrst_done", 16'(done), 16'd0);
    step();
    RST = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) pulses++;
    end
    chk("mrst_nodone", 16'(pulses), 16'd0);
    chk("mrst_out2",   out,          16'h0000);

    // CMP
    run_op("cmp1", 2'd1, 16'h0001, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 4);
    run_op("cmp0", 2'd1, 16'h0000, 16'h5555, 16'h0000, 1'b1, 1'b0, 4);
    run_op("cmp8", 2'd1, 16'h8000, 16'h1234, 16'h8000, 1'b0, 1'b1, 4);
    run_op("cmp5", 2'd1, 16'h0005, 16'h0000, 16'hFFFB, 1'b0, 1'b0, 4);

    // AND and reserved
    run_op("and1", 2'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1);
    run_op("and2", 2'd2, 16'hFFFF, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0, 1);
    run_op("rsv",  2'd3, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1);

    // start held high; operands change mid-flight; back-to-back accept
    start = 1'b1; op = 2'd0; in1 = 16'h1111; in2 = 16'h2222;
    step();
    chk("hold_busy0", 16'(busy), 16'd1);
    in1 = 16'hFFFF; in2 = 16'h0001;
    step(); step(); step();
    chk("hold_nodone", 16'(done), 16'd0);
    step();
    chk("hold_done",  16'(done), 16'd1);
    chk("hold_out",   out,       16'h3333);
    chk("hold_carry", 16'(carry), 16'd0);
    chk("hold_busyd", 16'(busy), 16'd0);
    step();
    chk("b2b_busy", 16'(busy), 16'd1);
    chk("b2b_done", 16'(done), 16'd0);
    start = 1'b0;
    step(); step(); step(); step();
    chk("b2b_fin",   16'(done),  16'd1);
    chk("b2b_out",   out,        16'h0000);
    chk("b2b_carry", 16'(carry), 16'd1);

    // start pulse while busy is ignored
    step();
    start = 1'b1; op = 2'd0; in1 = 16'h0001; in2 = 16'h0001;
    step();
    start = 1'b0;
    step();
    start = 1'b1; op = 2'd2; in1 = 16'h0000; in2 = 16'h0000;
    step();
    start = 1'b0;
    chk("ign_out_mid", out, 16'h0000);
    chk("ign_busy",    16'(busy), 16'd1);
    step(); step();
    chk("ign_done", 16'(done), 16'd1);
    chk("ign_out",  out,       16'h0002);
    step();
    chk("ign_noacc",  16'(busy), 16'd0);
    chk("ign_done2",  16'(done), 16'd0);
    step();
    chk("ign_out2", out, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
